// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the keypad scanner.
// The master modport is the scanner; the slave modport is the keypad and consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output shift_col,
        output key_value,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  shift_col,
        input  key_value,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, press and release debounce,
// and a single-cycle strobe per accepted press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 500000
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master bus
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_REPORT   = 2'd2;
    localparam logic [1:0] ST_HELD     = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] dwell;
    logic [CW-1:0] deb_cnt;
    logic [3:0]    row_m;
    logic [3:0]    row_s;
    logic [3:0]    cand;
    logic [3:0]    shift_col_r;
    logic [3:0]    key_value_r;
    logic          key_valid_r;
    logic          key_held_r;
    logic [3:0]    row_low;
    logic          single_low;

    function automatic logic [3:0] rotl(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Exactly one row low; two or more low rows are treated as no key.
    always_comb begin
        row_low    = ~row_s;
        single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_SCAN;
            dwell       <= '0;
            deb_cnt     <= '0;
            row_m       <= '1;
            row_s       <= '1;
            cand        <= '1;
            shift_col_r <= 4'b1110;
            key_value_r <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            row_m       <= bus.row;
            row_s       <= row_m;
            key_valid_r <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (single_low) begin
                            cand    <= row_s;
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            shift_col_r <= rotl(shift_col_r);
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s == cand) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt     <= '0;
                            state       <= ST_REPORT;
                            key_valid_r <= 1'b1;
                            key_held_r  <= 1'b1;
                            key_value_r <= key_code(low_index(cand), low_index(shift_col_r));
                        end else begin
                            deb_cnt <= deb_cnt + CW'(1);
                        end
                    end else begin
                        // Re-dwell on the same column before sampling again.
                        deb_cnt <= '0;
                        dwell   <= '0;
                        state   <= ST_SCAN;
                    end
                end
                ST_REPORT: begin
                    deb_cnt <= '0;
                    state   <= ST_HELD;
                end
                ST_HELD: begin
                    if (row_s != 4'hF) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt     <= '0;
                        dwell       <= '0;
                        key_held_r  <= 1'b0;
                        shift_col_r <= rotl(shift_col_r);
                        state       <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

    assign bus.shift_col = shift_col_r;
    assign bus.key_value = key_value_r;
    assign bus.key_valid = key_valid_r;
    assign bus.key_held  = key_held_r;

endmodule
